nibble_swap_arbiter: RTL
========================

Name: nibble_swap_arbiter

Overview:
- Shares one registered nibble-swap engine among NUM_REQ requesters.
- Requesters are served round-robin. Each accepted request is either half-swapped or passed through, per its own swap bit.
- The result is presented on a single response port with a valid/ready handshake and a one-entry output register.
- Sits between the request sources (e.g. bus-side byte producers) and the downstream consumer. It replaces per-requester swapper instances.

Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- DATA_W, default 8: data width; must be even. The swap exchanges [DATA_W-1:DATA_W/2] with [DATA_W/2-1:0].
- ID_W, default 2: width of the requester index; equals clog2(NUM_REQ).
- CNT_W, default 16: width of the swap-statistics counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_swap  input  NUM_REQ  per-requester op: 1 = swap halves, 0 = pass through unchanged.
- req_data  input  NUM_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_W  result data.
- rsp_id  output  ID_W  index of the requester that produced rsp_data.
- swap_count  output  CNT_W  saturating count of accepted requests with req_swap=1.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, swap_count=0.
  - Round-robin pointer rr_ptr=0; state EMPTY.
  - req_ready=0 while reset is asserted.
- States: EMPTY (output register empty) and FULL (rsp_valid=1).
- Accept condition, can_accept = (state==EMPTY) || rsp_ready.
- Grant selection (combinational):
  - The grant is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1.
  - req_ready[grant]=1 only when can_accept is true and some req_valid is high. All other req_ready bits are 0.
  - req_ready never depends on req_data or req_swap.
- On an accept edge (req_valid[g] && req_ready[g]):
  - rsp_data <= req_swap[g] ? {lo, hi} of req_data[g] : req_data[g].
  - rsp_id <= g; rsp_valid <= 1; state -> FULL.
  - rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Latency: exactly 1 clock from accept edge to rsp_valid=1. Throughput is 1 result/cycle when rsp_ready is held at 1.
- FULL with rsp_ready=0: rsp_data and rsp_id are held stable, all req_ready=0, rr_ptr is unchanged.
- FULL with rsp_ready=1 and no request: rsp_valid <= 0, state -> EMPTY.
- FULL with rsp_ready=1 and a request: drain and refill in the same cycle. rsp_valid stays 1 with the new data.
- No pending request: rr_ptr is unchanged.
- swap_count: increments by 1 on each accept with req_swap[g]=1. It saturates at all-ones and does not wrap.
- req_valid deasserted before being granted: no effect. The requester is simply not selected.
- Reset asserted mid-transfer: the pending response is discarded, with no partial output.

Decomposition:
- Package nibble_swap_pkg holds:
  - the swap_halves function (parameterised by DATA_W);
  - the state enum {EMPTY, FULL};
  - the ID_W derivation helper.
- Sub-module rr_arbiter: parameterised by NUM_REQ. Takes the request vector and rr_ptr; returns the one-hot grant and the encoded index.
- Datapath, output register and counter stay in nibble_swap_arbiter.

Test Plan (NUM_REQ=4, DATA_W=8):
- Hold reset=0 for 2 cycles, then release -> rsp_valid=0, rsp_data=00, swap_count=0, req_ready=0000.
- req_valid=0001, req_data[0]=71, req_swap[0]=1, rsp_ready=1 -> req_ready=0001. Next cycle: rsp_valid=1, rsp_data=17, rsp_id=0, swap_count=1.
- req_valid=0010, req_data[1]=A5, req_swap[1]=0 -> rsp_data=A5, rsp_id=1; swap_count unchanged.
- All four valid and held, data 12/34/56/78, all swap=1, rsp_ready=1, rr_ptr=0 -> back-to-back responses:
  - 21 id0, 43 id1, 65 id2, 87 id3, then 21 id0;
  - one response per cycle.
- Response rsp_data=4B pending with rsp_ready=0 for 3 cycles while req_valid=1111 -> rsp_data=4B and rsp_id held, req_ready=0000. After rsp_ready=1, the next grant follows round-robin order.
- reset=0 asserted asynchronously mid-cycle while FULL -> rsp_valid=0 immediately, before the next clk edge; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/nibble_swap_pkg.sv
`default_nettype none
// ============================================================================
// nibble_swap_pkg : shared types and helpers for the nibble-swap arbiter
// Revision: 1.0
// ============================================================================
package nibble_swap_pkg;

  localparam int MAX_DATA_W = 64;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Exchanges the upper and lower halves of the low w bits; w must be even.
  function automatic logic [MAX_DATA_W-1:0] swap_halves(
    input logic [MAX_DATA_W-1:0] d,
    input int                    w
  );
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < w) begin
        if (i < w / 2) r[i] = d[i + w / 2];
        else           r[i] = d[i - w / 2];
      end
    end
    return r;
  endfunction

endpackage : nibble_swap_pkg
`default_nettype wire

// File: rtl/nibble_swap_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin search starting at ptr_i
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  assign any_o = |req_i;

  always_comb begin : p_search
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/nibble_swap_arbiter.sv
`default_nettype none
// ============================================================================
// nibble_swap_arbiter : round-robin shared nibble-swap engine, 1-entry output
// Revision: 1.0
// ============================================================================
module nibble_swap_arbiter
  import nibble_swap_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_swap,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          swap_count
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   swap_count_q, swap_count_d;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any_req;
  logic               w_can_accept;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_swap;
  logic [DATA_W-1:0]  w_result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_grant_idx),
    .any_o   (w_any_req)
  );

  // Reset gates the handshake so no grant is visible while state is cleared.
  assign w_can_accept = (state_q == EMPTY) || rsp_ready;
  assign w_accept     = reset && w_can_accept && w_any_req;
  assign req_ready    = w_accept ? w_grant : '0;

  assign w_sel_data = req_data[w_grant_idx * DATA_W +: DATA_W];
  assign w_sel_swap = req_swap[w_grant_idx];
  assign w_result   = w_sel_swap
                    ? DATA_W'(swap_halves(MAX_DATA_W'(w_sel_data), DATA_W))
                    : w_sel_data;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    swap_count_d = swap_count_q;

    if (w_accept) begin
      state_d    = FULL;
      rsp_data_d = w_result;
      rsp_id_d   = w_grant_idx;
      rr_ptr_d   = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                       : w_grant_idx + ID_W'(1);
      if (w_sel_swap && (swap_count_q != '1)) begin
        swap_count_d = swap_count_q + CNT_W'(1);
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      rr_ptr_q     <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      swap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      swap_count_q <= swap_count_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign swap_count = swap_count_q;

endmodule : nibble_swap_arbiter
`default_nettype wire
